// File: rtl/calc_keypad_pkg.sv
// Shared constants and the on-screen keypad layout for the calculator front end.
package calc_keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 6;

  localparam logic [1:0] RST_ROW = 2'd3;
  localparam logic [2:0] RST_COL = 3'd1;

  localparam logic [4:0] KEY_ADD  = 5'h10;
  localparam logic [4:0] KEY_SUB  = 5'h11;
  localparam logic [4:0] KEY_MUL  = 5'h12;
  localparam logic [4:0] KEY_DIV  = 5'h13;
  localparam logic [4:0] KEY_SQRT = 5'h14;
  localparam logic [4:0] KEY_EQ   = 5'h15;
  localparam logic [4:0] KEY_CLR  = 5'h16;
  localparam logic [4:0] KEY_BKSP = 5'h17;

  // One action per cycle, chosen from the button press pulses.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_SEL,
    ACT_UP,
    ACT_DOWN,
    ACT_LEFT,
    ACT_RIGHT
  } action_t;

  // Map a cursor position to the key code printed on that cell.
  function automatic logic [4:0] key_at(input logic [1:0] row, input logic [2:0] col);
    logic [4:0] code;
    code = 5'h00;
    case (row)
      2'd0: case (col)
        3'd0: code = 5'h0C;
        3'd1: code = 5'h0D;
        3'd2: code = 5'h0E;
        3'd3: code = 5'h0F;
        3'd4: code = KEY_SQRT;
        3'd5: code = KEY_CLR;
        default: code = 5'h00;
      endcase
      2'd1: case (col)
        3'd0: code = 5'h04;
        3'd1: code = 5'h05;
        3'd2: code = 5'h06;
        3'd3: code = KEY_ADD;
        3'd4: code = KEY_DIV;
        3'd5: code = KEY_MUL;
        default: code = 5'h00;
      endcase
      2'd2: case (col)
        3'd0: code = 5'h07;
        3'd1: code = 5'h08;
        3'd2: code = 5'h09;
        3'd3: code = 5'h0A;
        3'd4: code = 5'h0B;
        3'd5: code = KEY_EQ;
        default: code = 5'h00;
      endcase
      default: case (col)
        3'd0: code = 5'h00;
        3'd1: code = 5'h01;
        3'd2: code = 5'h02;
        3'd3: code = 5'h03;
        3'd4: code = KEY_SUB;
        3'd5: code = KEY_BKSP;
        default: code = 5'h00;
      endcase
    endcase
    return code;
  endfunction

endpackage

// File: rtl/calc_keypad_nav_btn_debounce.sv
// Single push-button conditioner: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle press pulse on each accepted 0->1 change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronize, count disagreement cycles, flip the level once the count has been reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES)) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/calc_keypad_nav.sv
// Calculator keypad front end: debounces five buttons, moves a cursor over the
// 4x6 on-screen keypad and hands the selected key to the core via valid/ready.
module calc_keypad_nav
  import calc_keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BM,
  input  logic       BA,
  input  logic       BB,
  input  logic       BD,
  input  logic       BI,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [4:0] key_code,
  output logic [1:0] cur_row,
  output logic [2:0] cur_col
);

  logic    press_m;
  logic    press_a;
  logic    press_b;
  logic    press_d;
  logic    press_i;
  action_t action;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_m (.clk(CLK), .rst(RST), .raw(BM), .press(press_m));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (.clk(CLK), .rst(RST), .raw(BA), .press(press_a));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (.clk(CLK), .rst(RST), .raw(BB), .press(press_b));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (.clk(CLK), .rst(RST), .raw(BD), .press(press_d));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_i (.clk(CLK), .rst(RST), .raw(BI), .press(press_i));

  // Pick the single highest-priority press; the rest of this cycle's presses are discarded.
  always_comb begin
    action = ACT_NONE;
    if (press_m)      action = ACT_SEL;
    else if (press_a) action = ACT_UP;
    else if (press_b) action = ACT_DOWN;
    else if (press_i) action = ACT_LEFT;
    else if (press_d) action = ACT_RIGHT;
  end

  // Cursor moves one cell per action and saturates at the grid edges.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_row <= RST_ROW;
      cur_col <= RST_COL;
    end else begin
      case (action)
        ACT_UP:    if (cur_row != 2'd0)           cur_row <= cur_row - 2'd1;
        ACT_DOWN:  if (cur_row != 2'(ROWS - 1))   cur_row <= cur_row + 2'd1;
        ACT_LEFT:  if (cur_col != 3'd0)           cur_col <= cur_col - 3'd1;
        ACT_RIGHT: if (cur_col != 3'(COLS - 1))   cur_col <= cur_col + 3'd1;
        default: ;
      endcase
    end
  end

  // Key output register: consume on handshake, load on select only when empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      key_valid <= 1'b0;
      key_code  <= 5'h00;
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end else if (action == ACT_SEL && !key_valid) begin
      key_valid <= 1'b1;
      key_code  <= key_at(cur_row, cur_col);
    end
  end

endmodule

// File: doc/calc_keypad_nav.md
# calc_keypad_nav

Front-end input block of the calculator. It turns the five raw push buttons into debounced single-cycle events. Centre, up, down, right and left map to BM, BA, BB, BD and BI. The block moves a cursor over a fixed 4×6 on-screen keypad and issues the selected key code to the calculator core over a valid/ready handshake. The cursor position is exported to the VGA renderer for key highlighting.

## Interface
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required before a button level change is accepted; must be ≥1. Benches use 4.
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- BM, BA, BB, BD, BI  in  1 each  raw buttons (select, up, down, right, left); asynchronous, may bounce.
- key_ready  in  1  core accepts key_code this cycle.
- key_valid  out  1  key_code holds an unconsumed key.
- key_code  out  5  selected key.
- cur_row  out  2  cursor row, 0 = top.
- cur_col  out  3  cursor column, 0 = left, range 0..5.

## Operation
- Layout, row by row, columns 0..5:
  - Row 0: C D E F √ CLR
  - Row 1: 4 5 6 + / ×
  - Row 2: 7 8 9 A B =
  - Row 3: 0 1 2 3 − BKSP
- Key codes:
  - 0x00–0x0F: hex digits.
  - 0x10: +. 0x11: −. 0x12: ×. 0x13: /.
  - 0x14: √. 0x15: =. 0x16: CLR. 0x17: BKSP.
- Per-button conditioning:
  - 2-flop synchronizer feeds a debounced level register.
  - A counter counts consecutive cycles in which the synchronized level differs from the debounced level; any agreement clears it.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips.
  - A 0→1 flip produces a one-cycle press pulse. Releases produce nothing.
- Only one action is taken per cycle. Priority is BM > BA > BB > BI > BD; lower-priority pulses in the same cycle are discarded.
- Movement:
  - Up/down change cur_row by ∓1; left/right change cur_col by ∓1.
  - The cursor saturates at the grid edges; there is no wrap.
- Select:
  - If key_valid=0: load key_code from the layout at the current cursor and set key_valid.
  - If key_valid=1: the press is dropped. Movement is still allowed while a key is pending.
- Handshake:
  - key_valid clears on any edge where key_valid && key_ready.
  - key_code stays stable while key_valid=1.
  - A select pulse in the same cycle as the consuming handshake is dropped.

## Timing
- Reset values: cur_row=3, cur_col=1 (key "1"), key_valid=0, key_code=0. All synchronizers, debounced levels and counters are 0.
- Press latency: a raw level first sampled high at edge k, and held, gives a press pulse during the cycle after edge k+2+DEBOUNCE_CYCLES.
- cur_row, cur_col and key_valid/key_code update on the edge that samples the pulse, i.e. one cycle after the pulse.
- Pulses shorter than DEBOUNCE_CYCLES synchronized cycles are ignored.
- A button held across reset deassertion produces one press after the latency above.
- RST mid-operation discards a pending key (key_valid→0 next cycle) and recentres the cursor to (3,1).

## Structure
- Package calc_keypad_pkg holds:
  - key-code constants;
  - ROWS=4, COLS=6 and reset cursor constants;
  - the layout lookup function (row, col → 5-bit code).
- Sub-module btn_debounce (synchronizer, counter and press pulse, parameter DEBOUNCE_CYCLES), instantiated five times.
- Top level: priority arbitration, cursor registers, key output register.

## Test plan
- Reset, then BA, BM (10-cycle presses, DEBOUNCE_CYCLES=4) → cursor (2,1), key_code=0x08, key_valid=1; key_ready pulse → key_valid=0.
- Continuing: BD×3, BM → 0x0B; BA, BM → 0x13; BB, BM → 0x0B; BD×5, BM → 0x15 (cursor saturates at col 5). Each key consumed before the next select.
- Glitches: BA high 3 cycles → cursor unchanged; BA toggling every cycle for 20 cycles → no move; BA high 10 cycles → exactly one move.
- Backpressure: key_ready=0, BM at (3,1) → 0x01 held; move right, BM again → still 0x01; key_ready=1 for one cycle → key_valid=0 next cycle, no second key.
- Simultaneous BA and BD pulses in the same cycle → only the up move applied. BI at col 0 and BB at row 3 → cursor unchanged.
- Reset with key_valid=1 → key_valid=0 and cursor (3,1) one cycle after RST is sampled.
